// File: rtl/gem_rx_frame_fifo.sv
// Frame-aware RX buffer: words are written speculatively and become visible only
// when a good frame ends; bad, oversized or overflowing frames are rewound and counted.
module gem_rx_frame_fifo #(
    parameter int DEPTH           = 1024,
    parameter int STAT_DEPTH      = 16,
    parameter int MAX_FRAME_BYTES = 1536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [1:0]  in_bytes,
    input  logic        in_err,
    input  logic        data_rd_en,
    output logic [31:0] data_rd_data,
    output logic        data_empty,
    input  logic        stat_rd_en,
    output logic [15:0] stat_rd_data,
    output logic        stat_empty,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STAT_DEPTH);
    localparam logic [AW:0] L_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [SW:0] L_SDEPTH = (SW+1)'(STAT_DEPTH);
    localparam logic [15:0] L_MAX    = 16'(MAX_FRAME_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DISC = 2'd2;

    logic [31:0] r_mem      [DEPTH];
    logic [15:0] r_stat_mem [STAT_DEPTH];

    logic [1:0]  r_state;
    logic [AW:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [SW:0] r_stat_wr, r_stat_rd;
    logic [15:0] r_len, r_drop;
    logic [31:0] r_data_out;
    logic [15:0] r_stat_out;

    logic        w_sop_start, w_accept, w_space, w_stat_full, w_good, w_old_drop;
    logic        w_drop_new, w_we, w_stat_we, w_data_pop, w_stat_pop;
    logic [AW:0] w_base, w_wr_nxt, w_commit_nxt;
    logic [15:0] w_add, w_len_new, w_len_nxt;
    logic [1:0]  w_state_nxt, w_drop_inc;
    logic [16:0] w_drop_sum;

    // A new sop always rewinds to the commit point, so the new frame's first word
    // lands where the abandoned frame started and space is judged from there.
    always_comb begin
        w_sop_start = in_valid & in_sop;
        w_accept    = in_valid & (in_sop | (r_state == S_RECV));
        w_base      = w_sop_start ? r_commit_ptr : r_wr_ptr;
        w_space     = (w_base - r_rd_ptr) != L_DEPTH;
        w_add       = in_eop ? ((in_bytes == 2'd0) ? 16'd4 : {14'd0, in_bytes}) : 16'd4;
        w_len_new   = (w_sop_start ? 16'd0 : r_len) + w_add;
        w_stat_full = (r_stat_wr - r_stat_rd) == L_SDEPTH;
        w_good      = ~in_err & (w_len_new <= L_MAX) & ~w_stat_full;
        w_old_drop  = w_sop_start & (r_state != S_IDLE);
        w_data_pop  = data_rd_en & (r_rd_ptr != r_commit_ptr);
        w_stat_pop  = stat_rd_en & (r_stat_rd != r_stat_wr);
    end

    // Frame state machine: write, finalize (commit or rewind) and discard handling.
    always_comb begin
        w_state_nxt  = ((r_state == S_RECV) || (r_state == S_DISC)) ? r_state : S_IDLE;
        w_wr_nxt     = r_wr_ptr;
        w_commit_nxt = r_commit_ptr;
        w_len_nxt    = r_len;
        w_we         = 1'b0;
        w_stat_we    = 1'b0;
        w_drop_new   = 1'b0;
        if (w_accept) begin
            if (w_space) begin
                w_we      = 1'b1;
                w_wr_nxt  = w_base + 1'b1;
                w_len_nxt = w_len_new;
                if (in_eop) begin
                    w_state_nxt = S_IDLE;
                    if (w_good) begin
                        w_commit_nxt = w_base + 1'b1;
                        w_stat_we    = 1'b1;
                    end else begin
                        w_drop_new = 1'b1;
                        w_wr_nxt   = r_commit_ptr;
                    end
                end else if (w_len_new > L_MAX) begin
                    w_state_nxt = S_DISC;
                end else begin
                    w_state_nxt = S_RECV;
                end
            end else begin
                w_wr_nxt = w_base;
                if (in_eop) begin
                    w_drop_new  = 1'b1;
                    w_wr_nxt    = r_commit_ptr;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DISC;
                end
            end
        end else if (in_valid & in_eop & (r_state == S_DISC)) begin
            w_drop_new  = 1'b1;
            w_wr_nxt    = r_commit_ptr;
            w_state_nxt = S_IDLE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
        w_drop_inc = {1'b0, w_old_drop} + {1'b0, w_drop_new};
        w_drop_sum = {1'b0, r_drop} + {15'd0, w_drop_inc};
    end

    // Data and status storage (no reset, maps onto block RAM).
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_base[AW-1:0]] <= in_data;
        end
        if (w_stat_we) begin
            r_stat_mem[r_stat_wr[SW-1:0]] <= w_len_new;
        end
    end

    // Pointers, state, counters and registered read ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_stat_wr    <= '0;
            r_stat_rd    <= '0;
            r_len        <= 16'd0;
            r_drop       <= 16'd0;
            r_data_out   <= 32'd0;
            r_stat_out   <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_nxt;
            r_commit_ptr <= w_commit_nxt;
            r_len        <= w_len_nxt;
            r_drop       <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_stat_we) begin
                r_stat_wr <= r_stat_wr + 1'b1;
            end else begin
                r_stat_wr <= r_stat_wr;
            end
            if (w_data_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
            end else begin
                r_rd_ptr   <= r_rd_ptr;
                r_data_out <= r_data_out;
            end
            if (w_stat_pop) begin
                r_stat_rd  <= r_stat_rd + 1'b1;
                r_stat_out <= r_stat_mem[r_stat_rd[SW-1:0]];
            end else begin
                r_stat_rd  <= r_stat_rd;
                r_stat_out <= r_stat_out;
            end
        end
    end

    assign data_rd_data = r_data_out;
    assign stat_rd_data = r_stat_out;
    assign data_empty   = (r_rd_ptr == r_commit_ptr);
    assign stat_empty   = (r_stat_rd == r_stat_wr);
    assign drop_count   = r_drop;

endmodule

// File: tb/tb_gem_rx_frame_fifo.sv
// Bench for gem_rx_frame_fifo: directed frame table, corner sequences and random
// traffic, all compared against a queue-based reference model.
module tb_gem_rx_frame_fifo;

    localparam int DEPTH = 16;
    localparam int SD    = 4;
    localparam int MAXB  = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sop, in_eop, in_err, data_rd_en, stat_rd_en;
    logic [31:0] in_data, data_rd_data;
    logic [1:0]  in_bytes;
    logic [15:0] stat_rd_data, drop_count;
    logic        data_empty, stat_empty;

    always #5 clk = ~clk;

    gem_rx_frame_fifo #(.DEPTH(DEPTH), .STAT_DEPTH(SD), .MAX_FRAME_BYTES(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_bytes(in_bytes), .in_err(in_err),
        .data_rd_en(data_rd_en), .data_rd_data(data_rd_data), .data_empty(data_empty),
        .stat_rd_en(stat_rd_en), .stat_rd_data(stat_rd_data), .stat_empty(stat_empty),
        .drop_count(drop_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: committed words, in-flight frame words, status lengths.
    logic [31:0] m_data[$];
    logic [31:0] m_cur[$];
    logic [15:0] m_stat[$];
    int          m_len, m_mode, m_drop;
    logic [31:0] m_rd;
    logic [15:0] m_srd;

    typedef struct {
        int         nwords;
        logic [1:0] bytes;
        bit         err;
        bit         exp_ok;
        int         exp_len;
        int         exp_drops;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_data.delete(); m_cur.delete(); m_stat.delete();
        m_len = 0; m_mode = 0; m_drop = 0; m_rd = 32'd0; m_srd = 16'd0;
    endtask

    task automatic model_step(input bit v, input bit sop, input bit eop, input logic [1:0] by,
                              input bit er, input logic [31:0] d, input bit dp, input bit sp);
        int dsz, ssz, drops, add;
        bit sfull, accept;
        dsz = m_data.size(); ssz = m_stat.size(); sfull = (ssz == SD);
        drops = 0; accept = 1'b0;
        if (v && sop) begin
            if (m_mode != 0) drops++;
            m_cur.delete(); m_len = 0; accept = 1'b1;
        end else if (v && m_mode == 1) begin
            accept = 1'b1;
        end else if (v && m_mode == 2 && eop) begin
            drops++; m_cur.delete(); m_mode = 0;
        end
        if (accept) begin
            if (dsz + m_cur.size() < DEPTH) begin
                add = eop ? ((by == 2'd0) ? 4 : int'(by)) : 4;
                m_cur.push_back(d);
                m_len += add;
                if (eop) begin
                    if (!er && m_len <= MAXB && !sfull) begin
                        foreach (m_cur[i]) m_data.push_back(m_cur[i]);
                        m_stat.push_back(16'(m_len));
                    end else begin
                        drops++;
                    end
                    m_cur.delete(); m_mode = 0;
                end else begin
                    m_mode = (m_len > MAXB) ? 2 : 1;
                end
            end else if (eop) begin
                drops++; m_cur.delete(); m_mode = 0;
            end else begin
                m_mode = 2;
            end
        end
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
        if (dp && dsz > 0) m_rd = m_data.pop_front();
        if (sp && ssz > 0) m_srd = m_stat.pop_front();
    endtask

    task automatic compare_all();
        check("data_empty", {31'd0, data_empty}, {31'd0, m_data.size() == 0});
        check("stat_empty", {31'd0, stat_empty}, {31'd0, m_stat.size() == 0});
        check("drop_count", {16'd0, drop_count}, 32'(m_drop));
        check("data_rd_data", data_rd_data, m_rd);
        check("stat_rd_data", {16'd0, stat_rd_data}, {16'd0, m_srd});
    endtask

    task automatic tick(input bit v, input bit sop, input bit eop, input logic [1:0] by,
                        input bit er, input logic [31:0] d, input bit dp, input bit sp);
        in_valid = v; in_sop = sop; in_eop = eop; in_bytes = by; in_err = er; in_data = d;
        data_rd_en = dp; stat_rd_en = sp;
        @(posedge clk);
        model_step(v, sop, eop, by, er, d, dp, sp);
        #1;
        compare_all();
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n, input logic [1:0] by, input bit er);
        for (int i = 0; i < n; i++)
            tick(1'b1, i == 0, i == n - 1, by, er, $urandom, 1'b0, 1'b0);
    endtask

    task automatic pop_stat();
        tick(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic drain_data(output int cnt);
        cnt = m_data.size();
        for (int i = 0; i < cnt && i < 64; i++)
            tick(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        tbl[0] = '{4,  2'd2, 1'b0, 1'b1, 14, 0};
        tbl[1] = '{2,  2'd0, 1'b0, 1'b1, 8,  0};
        tbl[2] = '{3,  2'd3, 1'b1, 1'b0, 0,  1};
        tbl[3] = '{1,  2'd1, 1'b0, 1'b1, 1,  1};
        tbl[4] = '{15, 2'd0, 1'b0, 1'b1, 60, 1};
        tbl[5] = '{16, 2'd1, 1'b0, 1'b0, 0,  2};
        tbl[6] = '{20, 2'd0, 1'b0, 1'b0, 0,  3};
        tbl[7] = '{8,  2'd0, 1'b0, 1'b1, 32, 3};

        rst_n = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_bytes = 2'd0; in_err = 1'b0;
        in_data = 32'd0; data_rd_en = 1'b0; stat_rd_en = 1'b0;
        model_reset();
        #12;
        check("rst_data_empty", {31'd0, data_empty}, 32'd1);
        check("rst_stat_empty", {31'd0, stat_empty}, 32'd1);
        check("rst_drop_count", {16'd0, drop_count}, 32'd0);
        check("rst_data_rd", data_rd_data, 32'd0);
        check("rst_stat_rd", {16'd0, stat_rd_data}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            send_frame(tbl[k].nwords, tbl[k].bytes, tbl[k].err);
            idle();
            check("tbl_drops", {16'd0, drop_count}, 32'(tbl[k].exp_drops));
            if (tbl[k].exp_ok) begin
                pop_stat();
                check("tbl_len", {16'd0, stat_rd_data}, 32'(tbl[k].exp_len));
                drain_data(cnt);
                check("tbl_words", 32'(cnt), 32'(tbl[k].nwords));
            end else begin
                check("tbl_drop_empty", {30'd0, stat_empty, data_empty}, 32'd3);
            end
        end

        // sop mid-frame abandons the first frame
        tick(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, $urandom, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, $urandom, 1'b0, 1'b0);
        send_frame(3, 2'd0, 1'b0);
        idle();
        check("midsop_drops", {16'd0, drop_count}, 32'd4);
        pop_stat();
        check("midsop_len", {16'd0, stat_rd_data}, 32'd12);
        drain_data(cnt);
        check("midsop_words", 32'(cnt), 32'd3);

        // overflow behind committed data
        send_frame(12, 2'd0, 1'b0);
        send_frame(6, 2'd0, 1'b0);
        idle();
        check("ovf_drops", {16'd0, drop_count}, 32'd5);
        pop_stat();
        check("ovf_len", {16'd0, stat_rd_data}, 32'd48);
        drain_data(cnt);
        check("ovf_words", 32'(cnt), 32'd12);

        // status FIFO full
        for (int i = 0; i < SD; i++) send_frame(1, 2'd2, 1'b0);
        send_frame(1, 2'd2, 1'b0);
        idle();
        check("sfull_drops", {16'd0, drop_count}, 32'd6);
        pop_stat();
        check("sfull_first_len", {16'd0, stat_rd_data}, 32'd2);
        send_frame(1, 2'd3, 1'b0);
        idle();
        check("sfull_accept_drops", {16'd0, drop_count}, 32'd6);
        for (int i = 0; i < SD; i++) pop_stat();
        check("sfull_last_len", {16'd0, stat_rd_data}, 32'd3);
        drain_data(cnt);
        check("sfull_words", 32'(cnt), 32'd5);

        // pop and commit in the same cycle
        send_frame(1, 2'd0, 1'b0);
        idle();
        tick(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, $urandom, 1'b1, 1'b1);
        idle();
        check("popcommit_nonempty", {30'd0, stat_empty, data_empty}, 32'd0);
        pop_stat();
        check("popcommit_len", {16'd0, stat_rd_data}, 32'd1);
        drain_data(cnt);

        // reset while receiving
        send_frame(2, 2'd0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, $urandom, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, $urandom, 1'b0, 1'b0);
        in_valid = 1'b0; in_sop = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_empties", {30'd0, stat_empty, data_empty}, 32'd3);
        check("midrst_drops", {16'd0, drop_count}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        send_frame(1, 2'd1, 1'b0);
        idle();
        pop_stat();
        check("midrst_len", {16'd0, stat_rd_data}, 32'd1);
        drain_data(cnt);
        check("midrst_words", 32'(cnt), 32'd1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
                 2'($urandom), ($urandom % 10) == 0, $urandom,
                 ($urandom % 3) == 0, ($urandom % 3) == 0);
        end
        idle();
        for (int i = 0; i < SD; i++) pop_stat();
        drain_data(cnt);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
